decode_stage_hs: RTL
====================

Name: decode_stage_hs

Overview:
Parametrised decode stage. Holds the scalar register file and decodes immediates and operand/destination fields. It sits between fetch and execute, with valid/ready handshakes on both sides. It has a load-use scoreboard, so it interlocks on pending load destinations. It supports NUM_WB write-back ports with write-through bypass.

Parameters:
XLEN, 32, datapath width; immediates sign-extend to XLEN.
NUM_REGS, 32, architectural registers; legal values 16 or 32. Register index width RW = $clog2(NUM_REGS).
NUM_WB, 2, independent write-back ports (1..4).
SP_INIT, 32'h300, reset value of x2.
GP_INIT, 32'h300, reset value of x3.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  kill the instruction held in the output register and drop in_* this cycle
in_valid  in  1  fetch offers an instruction
in_ready  out  1  stage accepts the offered instruction
in_instr  in  32  RV32I instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  registered decoded instruction is valid
out_ready  in  1  execute accepts it
out_rs1, out_rs2  out  XLEN each  operand values
out_a1, out_a2, out_rd  out  RW each  register indices
out_imm  out  XLEN  extended immediate
out_pc  out  XLEN  registered PC
out_reg_write  out  1  instruction writes rd (rd != 0)
out_is_load  out  1  opcode is LOAD
wb_en  in  NUM_WB  per-port write enable
wb_rd  in  NUM_WB*RW  per-port destination index
wb_data  in  NUM_WB*XLEN  per-port write data
wb_ld_done  in  NUM_WB  per-port flag: this write completes a load

Behaviour:
- Reset (rst low, asynchronous):
  - out_valid=0; out_* data=0.
  - Scoreboard all 0.
  - Register file all 0 except x2=SP_INIT and x3=GP_INIT.
  - in_ready=0 while reset is asserted.
- Opcode decode:
  - LOAD, OP-IMM, JALR: I-type. OP-IMM funct3 001/101 use SH (zero-extended shamt).
  - STORE: S-type. BRANCH: B-type. JAL: J-type. LUI, AUIPC: U-type (imm<<12). OP: imm=0.
- Register read and write flags:
  - rs1 is read unless the opcode is LUI, AUIPC or JAL.
  - rs2 is read for OP, STORE and BRANCH only.
  - Instruction writes rd unless STORE or BRANCH; out_reg_write is forced to 0 when rd==0.
- Register indices:
  - When NUM_REGS=16, index bit 4 is ignored.
  - x0 always reads 0 and writes to x0 are discarded.
- Operand read:
  - Combinational read from the register file with write-through bypass from all wb ports in the same cycle.
  - If several ports write the same rd, the highest port index wins, for both the bypass and the array write.
- Hazard:
  - A hazard exists if a read register (or a written rd, WAW) has its scoreboard bit set and no wb port with wb_ld_done clears that index this cycle.
  - A hazard also exists if the output register holds out_valid && out_is_load with out_rd equal to a read register or the written rd (nonzero).
- Handshake:
  - in_ready = !hazard && (!out_valid || out_ready) && !flush.
  - Accept occurs on in_valid && in_ready; the output register loads next edge, so latency is 1 cycle.
  - If out_ready && out_valid with no accept, out_valid drops to 0.
  - While out_valid && !out_ready, all out_* hold stable.
- Scoreboard:
  - Set bit[out_rd] on the output handshake (out_valid && out_ready) when out_is_load && out_rd != 0.
  - Clear bit[wb_rd[i]] when wb_en[i] && wb_ld_done[i].
  - If the same index is set and cleared in one cycle, set wins.
- Flush:
  - On the next edge out_valid=0 and nothing is accepted.
  - The scoreboard is unaffected, because only handed-off loads set bits.
- Register file writes are never blocked by stalls or flush.

Test Plan:
- Reset release: read x2 and x3 via ADDI x5,x2,0 -> out_rs1=32'h300 and out_imm=0, with out_valid one cycle after accept.
- Same-cycle bypass: wb_en[0]=1, wb_rd=7, data=0xDEAD while decoding ADD x1,x7,x0 -> out_rs1=0xDEAD. With ports 0 and 1 both writing x7 (0x1111 and 0x2222) -> 0x2222.
- Load-use stall:
  - LW x4 is handed off, followed by ADD x6,x4,x4 -> in_ready=0 until wb_ld_done on x4.
  - Accept occurs in the same cycle as the completing write; out_rs1 equals the load data.
- Back-pressure: hold out_ready=0 for 3 cycles -> out_* stable, in_ready=0. A flush during the hold -> out_valid=0 on the next edge.
- Immediates:
  - BEQ with offset -4 -> out_imm=32'hFFFFFFFC.
  - LUI 0xABCDE -> 32'hABCDE000.
  - SRAI shamt 31 -> 32'h1F.
- Asynchronous reset mid-stall: assert rst while out_valid=1 and the scoreboard is nonempty -> out_valid=0 and the scoreboard is cleared immediately, without a clock edge.

Source files
------------

// File: rtl/decode_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_hs
//  Purpose  : RV32I decode stage between fetch and execute. Holds the scalar
//             register file, decodes immediates and register fields, and
//             interlocks on pending load destinations through a scoreboard.
//             Write-back ports update the register file every cycle and are
//             bypassed combinationally into the operand read.
//  Ports    : clk, rst (async, active low), flush
//             in_valid/in_ready/in_instr/in_pc        fetch side handshake
//             out_valid/out_ready/out_*                execute side handshake
//             wb_en/wb_rd/wb_data/wb_ld_done           NUM_WB write-back ports
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage_hs #(
    parameter int               XLEN     = 32,
    parameter int               NUM_REGS = 32,
    parameter int               NUM_WB   = 2,
    parameter logic [XLEN-1:0]  SP_INIT  = 32'h300,
    parameter logic [XLEN-1:0]  GP_INIT  = 32'h300,
    localparam int              RW       = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_rs1,
    output logic [XLEN-1:0]        out_rs2,
    output logic [RW-1:0]          out_a1,
    output logic [RW-1:0]          out_a2,
    output logic [RW-1:0]          out_rd,
    output logic [XLEN-1:0]        out_imm,
    output logic [XLEN-1:0]        out_pc,
    output logic                   out_reg_write,
    output logic                   out_is_load,
    input  logic [NUM_WB-1:0]      wb_en,
    input  logic [NUM_WB*RW-1:0]   wb_rd,
    input  logic [NUM_WB*XLEN-1:0] wb_data,
    input  logic [NUM_WB-1:0]      wb_ld_done
);

    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] sb_q, sb_d;

    logic                out_valid_q,     out_valid_d;
    logic [XLEN-1:0]     out_rs1_q,       out_rs1_d;
    logic [XLEN-1:0]     out_rs2_q,       out_rs2_d;
    logic [RW-1:0]       out_a1_q,        out_a1_d;
    logic [RW-1:0]       out_a2_q,        out_a2_d;
    logic [RW-1:0]       out_rd_q,        out_rd_d;
    logic [XLEN-1:0]     out_imm_q,       out_imm_d;
    logic [XLEN-1:0]     out_pc_q,        out_pc_d;
    logic                out_reg_write_q, out_reg_write_d;
    logic                out_is_load_q,   out_is_load_d;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [RW-1:0]   w_a1, w_a2, w_rd;
    logic            w_rs1_used, w_rs2_used, w_writes;
    logic            w_reg_write, w_is_load;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;

    always_comb begin
        w_opcode   = in_instr[6:0];
        w_funct3   = in_instr[14:12];
        // Only the low RW bits of each field are kept, so with 16 registers
        // bit 4 of the index is simply ignored.
        w_a1       = in_instr[15 +: RW];
        w_a2       = in_instr[20 +: RW];
        w_rd       = in_instr[7 +: RW];
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
        w_writes   = 1'b1;
        w_imm32    = 32'd0;
        case (w_opcode)
            c_opc_load, c_opc_jalr: begin
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            c_opc_op_imm: begin
                // Shift-immediate forms carry an unsigned shamt, not a
                // signed immediate (funct7 must not leak into the value).
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_imm32 = {27'd0, in_instr[24:20]};
                end else begin
                    w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            c_opc_store: begin
                w_imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                w_rs2_used = 1'b1;
                w_writes   = 1'b0;
            end
            c_opc_branch: begin
                w_imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
                w_rs2_used = 1'b1;
                w_writes   = 1'b0;
            end
            c_opc_jal: begin
                w_imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
                w_rs1_used = 1'b0;
            end
            c_opc_lui, c_opc_auipc: begin
                w_imm32    = {in_instr[31:12], 12'd0};
                w_rs1_used = 1'b0;
            end
            c_opc_op: begin
                w_rs2_used = 1'b1;
            end
            default: ;
        endcase
        w_reg_write = w_writes && (w_rd != '0);
        w_is_load   = (w_opcode == c_opc_load);
        // Sign-extend the 32-bit immediate to the datapath width.
        w_imm       = {XLEN{w_imm32[31]}};
        w_imm[31:0] = w_imm32;
    end

    // ------------------------------------------------------------------
    // Operand read with write-through bypass. Ports are scanned in
    // ascending order so the highest-index writer overrides lower ones.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_rs1_val, w_rs2_val;

    always_comb begin
        w_rs1_val = regs_q[w_a1];
        w_rs2_val = regs_q[w_a2];
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_en[i] && wb_rd[i*RW +: RW] != '0) begin
                if (wb_rd[i*RW +: RW] == w_a1) w_rs1_val = wb_data[i*XLEN +: XLEN];
                if (wb_rd[i*RW +: RW] == w_a2) w_rs2_val = wb_data[i*XLEN +: XLEN];
            end
        end
        // x0 reads zero regardless of any write-back aimed at it.
        if (w_a1 == '0) w_rs1_val = '0;
        if (w_a2 == '0) w_rs2_val = '0;
    end

    // ------------------------------------------------------------------
    // Register file write: never gated by stalls or flush.
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_en[i] && wb_rd[i*RW +: RW] != '0) begin
                regs_d[wb_rd[i*RW +: RW]] = wb_data[i*XLEN +: XLEN];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and hazard detection
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] w_sb_clr, w_sb_eff;
    logic                w_out_fire;
    logic                w_haz_sb, w_haz_out, w_hazard, w_accept;

    always_comb begin
        w_sb_clr = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_en[i] && wb_ld_done[i]) w_sb_clr[wb_rd[i*RW +: RW]] = 1'b1;
        end
        // A load completing this cycle releases its dependants immediately;
        // the bypass supplies the data.
        w_sb_eff = sb_q & ~w_sb_clr;

        w_haz_sb = (w_rs1_used  && w_sb_eff[w_a1]) ||
                   (w_rs2_used  && w_sb_eff[w_a2]) ||
                   (w_reg_write && w_sb_eff[w_rd]);

        // A load still sitting in the output register is not yet in the
        // scoreboard but its result is equally unavailable.
        w_haz_out = out_valid_q && out_is_load_q && (out_rd_q != '0) &&
                    ((w_rs1_used  && w_a1 == out_rd_q) ||
                     (w_rs2_used  && w_a2 == out_rd_q) ||
                     (w_reg_write && w_rd == out_rd_q));

        w_hazard   = w_haz_sb || w_haz_out;
        w_out_fire = out_valid_q && out_ready;
    end

    assign in_ready = rst && !w_hazard && (!out_valid_q || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        sb_d = sb_q & ~w_sb_clr;
        // Set after clear so a simultaneous set/clear leaves the bit set.
        if (w_out_fire && out_is_load_q && out_rd_q != '0) begin
            sb_d[out_rd_q] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d     = out_valid_q;
        out_rs1_d       = out_rs1_q;
        out_rs2_d       = out_rs2_q;
        out_a1_d        = out_a1_q;
        out_a2_d        = out_a2_q;
        out_rd_d        = out_rd_q;
        out_imm_d       = out_imm_q;
        out_pc_d        = out_pc_q;
        out_reg_write_d = out_reg_write_q;
        out_is_load_d   = out_is_load_q;
        if (w_accept) begin
            out_valid_d     = 1'b1;
            out_rs1_d       = w_rs1_val;
            out_rs2_d       = w_rs2_val;
            out_a1_d        = w_a1;
            out_a2_d        = w_a2;
            out_rd_d        = w_rd;
            out_imm_d       = w_imm;
            out_pc_d        = in_pc;
            out_reg_write_d = w_reg_write;
            out_is_load_d   = w_is_load;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (r == 2) begin
                    regs_q[r] <= SP_INIT;
                end else if (r == 3) begin
                    regs_q[r] <= GP_INIT;
                end else begin
                    regs_q[r] <= '0;
                end
            end
            sb_q            <= '0;
            out_valid_q     <= 1'b0;
            out_rs1_q       <= '0;
            out_rs2_q       <= '0;
            out_a1_q        <= '0;
            out_a2_q        <= '0;
            out_rd_q        <= '0;
            out_imm_q       <= '0;
            out_pc_q        <= '0;
            out_reg_write_q <= 1'b0;
            out_is_load_q   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            sb_q            <= sb_d;
            out_valid_q     <= out_valid_d;
            out_rs1_q       <= out_rs1_d;
            out_rs2_q       <= out_rs2_d;
            out_a1_q        <= out_a1_d;
            out_a2_q        <= out_a2_d;
            out_rd_q        <= out_rd_d;
            out_imm_q       <= out_imm_d;
            out_pc_q        <= out_pc_d;
            out_reg_write_q <= out_reg_write_d;
            out_is_load_q   <= out_is_load_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_rs1       = out_rs1_q;
    assign out_rs2       = out_rs2_q;
    assign out_a1        = out_a1_q;
    assign out_a2        = out_a2_q;
    assign out_rd        = out_rd_q;
    assign out_imm       = out_imm_q;
    assign out_pc        = out_pc_q;
    assign out_reg_write = out_reg_write_q;
    assign out_is_load   = out_is_load_q;

endmodule
`default_nettype wire
